// File: rtl/ram_bus_master_if.sv
// Client request/response handshake plus the RAM enable/direction strobes of ram_bus_master.
// The tri-state data bus is kept outside this bundle as a plain inout on the master.
interface ram_bus_master_if #(
    parameter int BITW = 8
);
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [BITW-1:0] req_addr;
    logic [BITW-1:0] req_wdata;
    logic            resp_valid;
    logic            resp_write;
    logic [BITW-1:0] resp_rdata;
    logic            enable;
    logic            rw;

    modport master (
        input  req_valid,
        input  req_write,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output resp_valid,
        output resp_write,
        output resp_rdata,
        output enable,
        output rw
    );

    modport slave (
        output req_valid,
        output req_write,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  resp_valid,
        input  resp_write,
        input  resp_rdata,
        input  enable,
        input  rw
    );
endinterface

// File: rtl/ram_bus_master.sv
// Shared-bus RAM initiator: one request -> address phase, data phase, response pulse.
// Optional macro RAM_BUS_TURNAROUND_EN adds one idle TURN cycle after each response.
module ram_bus_master #(
    parameter int BITW = 8
) (
    input  logic             clk_i,
    input  logic             srst_i,
    ram_bus_master_if.master ctrl_if,
    inout  wire  [BITW-1:0]  bus_io
);

`ifdef RAM_BUS_TURNAROUND_EN
    typedef enum logic [2:0] {IDLE, ADDR, DATA_RD, DATA_WR, RESP, TURN} state_e;
`else
    typedef enum logic [2:0] {IDLE, ADDR, DATA_RD, DATA_WR, RESP} state_e;
`endif

    state_e          state_q, state_d;
    logic [BITW-1:0] addr_q, addr_d;
    logic [BITW-1:0] wdata_q, wdata_d;
    logic [BITW-1:0] rdata_q, rdata_d;
    logic            write_q, write_d;

    logic            req_ready;
    logic            enable;
    logic            rw;
    logic            resp_valid;
    logic            resp_write;
    logic            bus_oe;
    logic [BITW-1:0] bus_out;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            write_q <= write_d;
        end
    end

    // All outputs decode from the registered state, so req_ready never depends on req_valid.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        write_d    = write_q;
        req_ready  = 1'b0;
        enable     = 1'b0;
        rw         = 1'b0;
        resp_valid = 1'b0;
        resp_write = 1'b0;
        bus_oe     = 1'b0;
        bus_out    = '0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (ctrl_if.req_valid) begin
                    addr_d  = ctrl_if.req_addr;
                    wdata_d = ctrl_if.req_wdata;
                    write_d = ctrl_if.req_write;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                enable  = 1'b1;
                rw      = write_q;
                bus_oe  = 1'b1;
                bus_out = addr_q;
                state_d = write_q ? DATA_WR : DATA_RD;
            end
            DATA_WR: begin
                enable  = 1'b1;
                rw      = 1'b1;
                bus_oe  = 1'b1;
                bus_out = wdata_q;
                state_d = RESP;
            end
            DATA_RD: begin
                enable  = 1'b1;
                rdata_d = bus_io;
                state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_write = write_q;
`ifdef RAM_BUS_TURNAROUND_EN
                state_d    = TURN;
`else
                state_d    = IDLE;
`endif
            end
`ifdef RAM_BUS_TURNAROUND_EN
            TURN: begin
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus_io = bus_oe ? bus_out : {BITW{1'bz}};

    assign ctrl_if.req_ready  = req_ready;
    assign ctrl_if.enable     = enable;
    assign ctrl_if.rw         = rw;
    assign ctrl_if.resp_valid = resp_valid;
    assign ctrl_if.resp_write = resp_write;
    assign ctrl_if.resp_rdata = rdata_q;

endmodule
